// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles both requester ports, the clear controls and the memory-side bus of dmem_arbiter.
// Latency : none, wires only.
// Backpressure: requesters hold req and fields stable until gnt; memory side has no backpressure.
//
// Port summary
//   p0_* / p1_* : req, we, addr, wdata from the requester; gnt, rvalid, rdata back to it
//   clr_*       : clr_start pulse in; clr_busy level and clr_done pulse out
//   mem_*       : addr, wdata, we to the single-port memory; rdata from it
//   slave modport  : arbiter side
//   master modport : requester / memory side (testbench or surrounding SoC)
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    input  clr_start,
    output clr_busy, clr_done,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    output clr_start,
    input  clr_busy, clr_done,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter for two requesters on one single-port data memory, plus a zero-fill clear sequencer.
// Latency : grant is combinational in the request cycle; read data returns on rvalid one cycle after grant.
// Backpressure: a requester holds its request until gnt; while the clear runs (and its DONE cycle) nobody is granted.
//
// Port summary
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : dmem_arbiter_if.slave (p0/p1 request ports, clr controls, memory bus)
module dmem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_OFFSET     = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Last word index of the memory (DEPTH-1).
  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_LAST = '1;

  logic [1:0]                state;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic                      lp;        // port granted most recently
  logic                      rsp_vld;   // a read was granted last cycle
  logic                      rsp_port;  // which port that read belongs to

  logic                  arb_en;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rd_gnt;
  logic                  in_clear;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic                  mem_we_c;
  logic                  rv0;
  logic                  rv1;

  // Arbitration. Gating with rst keeps every output quiet while reset is held,
  // even though the state registers only update at the clock edge.
  always_comb begin
    arb_en   = rst && (state == ST_IDLE);
    in_clear = rst && (state == ST_CLEAR);
    // On contention the port that did not win last time goes first.
    gnt0     = arb_en && bus.p0_req && (!bus.p1_req || lp);
    gnt1     = arb_en && bus.p1_req && (!bus.p0_req || !lp);
    rd_gnt   = (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
  end

  // Clear address: word index placed at the byte-address offset, all other bits zero.
  always_comb begin
    clr_addr = '0;
    clr_addr[MEM_OFFSET +: MEM_ADDR_WIDTH] = idx;
  end

  // Memory-side mux. Upper/lower address bits from the requester pass through
  // untouched; the memory only decodes the word-index field.
  always_comb begin
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;
    if (in_clear) begin
      mem_addr_c = clr_addr;
      mem_we_c   = 1'b1;
    end else if (gnt0) begin
      mem_addr_c  = bus.p0_addr;
      mem_wdata_c = bus.p0_wdata;
      mem_we_c    = bus.p0_we;
    end else if (gnt1) begin
      mem_addr_c  = bus.p1_addr;
      mem_wdata_c = bus.p1_wdata;
      mem_we_c    = bus.p1_we;
    end
  end

  // Response routing: memory data is valid the cycle after the grant, so the
  // registered tag simply steers the live mem_rdata to the right port.
  always_comb begin
    rv0 = rst && rsp_vld && !rsp_port;
    rv1 = rst && rsp_vld &&  rsp_port;
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rv0;
  assign bus.p1_rvalid = rv1;
  assign bus.p0_rdata  = rv0 ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = rv1 ? bus.mem_rdata : '0;
  assign bus.clr_busy  = in_clear;
  assign bus.clr_done  = rst && (state == ST_DONE);
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_we    = mem_we_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      lp       <= 1'b1;
      rsp_vld  <= 1'b0;
      rsp_port <= 1'b0;
    end else begin
      rsp_vld  <= rd_gnt;
      rsp_port <= gnt1;
      if (gnt0 || gnt1) begin
        lp <= gnt1;
      end
      case (state)
        ST_IDLE: begin
          // Arbitration in this cycle already happened above; the clear
          // starts on the next cycle.
          if (bus.clr_start) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (idx == IDX_LAST) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter with a behavioural single-port memory and a read scoreboard.
// Latency : reads are expected on rvalid exactly one cycle after their grant.
// Backpressure: requests are held until granted; grant cycles are checked against fixed expectations.
module tb_dmem_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MAW   = 4;
  localparam int MO    = 2;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .MEM_OFFSET(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural memory: registers addr/data/we at the edge, read data valid the
  // following cycle, write committed at the next edge.
  logic [DW-1:0]  mem [DEPTH];
  logic           mem_init = 1'b0;
  logic [MAW-1:0] mq_idx;
  logic           mq_we = 1'b0;
  logic [DW-1:0]  mq_wdata;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | i;
      mem_init <= 1'b1;
    end else if (mq_we) begin
      mem[mq_idx] <= mq_wdata;
    end
    mq_idx   <= bus.mem_addr[MO +: MAW];
    mq_we    <= bus.mem_we;
    mq_wdata <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[mq_idx];

  // Reference contents and read scoreboard, owned by the monitor.
  logic [DW-1:0] model [DEPTH];
  logic          model_init = 1'b0;
  int            clr_cnt  = 0;  // bumped by the stimulus when a clear has completed
  int            clr_seen = 0;
  rsp_t          sb [$];

  always @(negedge clk) begin : mon
    rsp_t e;
    if (!model_init) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'hA500_0000 | i;
      model_init = 1'b1;
    end
    if (clr_seen != clr_cnt) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      clr_seen = clr_cnt;
    end
    if (!rst) begin
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_p0_rvalid", bus.p0_rvalid, !e.port);
        chk("rsp_p1_rvalid", bus.p1_rvalid, e.port);
        chk("rsp_data", e.port ? bus.p1_rdata : bus.p0_rdata, e.data);
      end else if (bus.p0_rvalid || bus.p1_rvalid) begin
        chk("rvalid_spurious", {bus.p1_rvalid, bus.p0_rvalid}, 2'b00);
      end
      if (bus.p0_gnt) begin
        if (bus.p0_we) model[bus.p0_addr[MO +: MAW]] = bus.p0_wdata;
        else sb.push_back({1'b0, model[bus.p0_addr[MO +: MAW]]});
      end
      if (bus.p1_gnt) begin
        if (bus.p1_we) model[bus.p1_addr[MO +: MAW]] = bus.p1_wdata;
        else sb.push_back({1'b1, model[bus.p1_addr[MO +: MAW]]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks every CLEAR cycle and the DONE cycle; clr_start is re-pulsed
  // mid-clear when pulse_at >= 0 to confirm it is ignored.
  task automatic run_clear(input int pulse_at);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("clr_busy", bus.clr_busy, 1'b1);
      chk("clr_mem_we", bus.mem_we, 1'b1);
      chk("clr_mem_addr", bus.mem_addr, k << MO);
      chk("clr_mem_wdata", bus.mem_wdata, '0);
      chk("clr_no_gnt", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
      chk("clr_done_early", bus.clr_done, 1'b0);
      step();
      bus.clr_start = (k == pulse_at);
    end
    bus.clr_start = 1'b0;
    @(negedge clk);
    chk("done_pulse", bus.clr_done, 1'b1);
    chk("done_busy", bus.clr_busy, 1'b0);
    chk("done_mem_we", bus.mem_we, 1'b0);
    chk("done_no_gnt", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
    clr_cnt++;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bus.clr_start = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h10; bus.p0_wdata = '0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h20; bus.p1_wdata = '0;

    // Reset held with both ports requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {bus.p1_gnt, bus.p0_gnt}, 2'b00);
      chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 2'b00);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_busy_done", {bus.clr_busy, bus.clr_done}, 2'b00);
      chk("rst_rdata", bus.p0_rdata | bus.p1_rdata, '0);
    end
    step();
    rst = 1'b1;

    // Contention: p0 first after reset, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_p0_gnt", bus.p0_gnt, (i % 2) == 0);
      chk("arb_p1_gnt", bus.p1_gnt, (i % 2) == 1);
      chk("arb_mem_addr", bus.mem_addr, ((i % 2) == 0) ? 32'h10 : 32'h20);
      step();
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    step();
    step();

    // Read-after-write on the same word (0x40 aliases word 0 here).
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h40; bus.p0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_wr_gnt", bus.p0_gnt, 1'b1);
    chk("raw_wr_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h40, 32'hDEAD_BEEF});
    step();
    bus.p0_we = 1'b0;
    @(negedge clk);
    chk("raw_rd_gnt", bus.p0_gnt, 1'b1);
    chk("raw_rd_mem_we", bus.mem_we, 1'b0);
    step();
    bus.p0_req = 1'b0;
    @(negedge clk);
    chk("raw_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 2'b01);
    chk("raw_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    step();

    // Preload a word from port 1.
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h24; bus.p1_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("pre_wr_gnt", bus.p1_gnt, 1'b1);
    step();
    bus.p1_req = 1'b0;
    step();

    // Clear overlapping a p1 read; p1 then keeps requesting through the clear.
    bus.clr_start = 1'b1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h24;
    @(negedge clk);
    chk("ovl_gnt", bus.p1_gnt, 1'b1);
    chk("ovl_busy", bus.clr_busy, 1'b0);
    step();
    bus.clr_start = 1'b0;
    bus.p1_addr = 32'h28;
    run_clear(2);
    @(negedge clk);
    chk("post_clr_p1_gnt", bus.p1_gnt, 1'b1);
    chk("single_done", bus.clr_done, 1'b0);
    step();
    bus.p1_req = 1'b0;

    // Back-to-back reads of every word must now return zero.
    bus.p0_req = 1'b1; bus.p0_we = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      bus.p0_addr = w << MO;
      @(negedge clk);
      chk("bb_gnt", bus.p0_gnt, 1'b1);
      chk("bb_no_done", bus.clr_done, 1'b0);
      step();
    end
    bus.p0_req = 1'b0;
    step();

    // Reset in the middle of a clear.
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_mem_addr", bus.mem_addr, k << MO);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_busy", bus.clr_busy, 1'b0);
      chk("mid_rst_done", bus.clr_done, 1'b0);
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_idle", {bus.clr_busy, bus.clr_done, bus.mem_we}, 3'b000);
      step();
    end
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    run_clear(-1);

    // A read after the restarted clear returns zero.
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h14;
    @(negedge clk);
    chk("final_gnt", bus.p1_gnt, 1'b1);
    step();
    bus.p1_req = 1'b0;
    step();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
